// File: rtl/rv_write_hs.sv
// rtl/rv_write_hs.sv - writeback stage with memory read-response handshake
module rv_write_hs #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-1:0] i_csr_data,
    input  logic [XLEN-3:0] i_pc_p4,
    input  logic            i_reg_write,
    input  logic [RD_W-1:0] i_rd,
    input  logic [1:0]      i_res_src,
    input  logic [2:0]      i_funct3,
    input  logic            i_mem_rvalid,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic [XLEN-1:0] o_data,
    output logic [RD_W-1:0] o_rd,
    output logic            o_reg_write,
    output logic            o_misalign,
    output logic            o_pend_valid,
    output logic [RD_W-1:0] o_pend_rd
);

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MEM = 2'd1;
    localparam logic [1:0] SRC_PC  = 2'd2;
    localparam logic [1:0] SRC_CSR = 2'd3;
    localparam int OFF_W = (XLEN == 64) ? 3 : 2;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_DONE,
        ST_LOAD
    } state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0] cap_alu;
    logic [XLEN-1:0] cap_csr;
    logic [XLEN-3:0] cap_pc_p4;
    logic            cap_reg_write;
    logic [RD_W-1:0] cap_rd;
    logic [1:0]      cap_res_src;
    logic [2:0]      cap_funct3;

    logic accept;
    logic commit;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= ST_EMPTY;
            cap_alu       <= '0;
            cap_csr       <= '0;
            cap_pc_p4     <= '0;
            cap_reg_write <= 1'b0;
            cap_rd        <= '0;
            cap_res_src   <= SRC_ALU;
            cap_funct3    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cap_alu       <= i_alu_result;
                cap_csr       <= i_csr_data;
                cap_pc_p4     <= i_pc_p4;
                cap_reg_write <= i_reg_write;
                cap_rd        <= i_rd;
                cap_res_src   <= i_res_src;
                cap_funct3    <= i_funct3;
            end
        end
    end

    // A load completing this cycle frees the stage, so the next op can be taken in the same cycle.
    always_comb begin
        state_nxt = state;
        o_ready   = 1'b1;
        commit    = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_DONE: commit = 1'b1;
            ST_LOAD: begin
                o_ready = i_mem_rvalid;
                commit  = i_mem_rvalid;
            end
            default: ;
        endcase
        accept = i_valid & o_ready;
        if (state != ST_LOAD || i_mem_rvalid) begin
            if (accept)
                state_nxt = (i_res_src == SRC_MEM) ? ST_LOAD : ST_DONE;
            else
                state_nxt = ST_EMPTY;
        end
    end

    logic [OFF_W-1:0] off;
    logic [6:0]       b_sh, h_sh, w_sh;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;
    logic [31:0]      lane_w;
    logic [XLEN-1:0]  load_data;
    logic             mis_addr;
    logic             misalign;

    always_comb begin
        off    = cap_alu[OFF_W-1:0];
        b_sh   = 7'(off) << 3;
        h_sh   = 7'(off >> 1) << 4;
        w_sh   = 7'(off >> 2) << 5;
        lane_b = 8'(i_mem_rdata >> b_sh);
        lane_h = 16'(i_mem_rdata >> h_sh);
        lane_w = 32'(i_mem_rdata >> w_sh);
        load_data = '0;
        mis_addr  = 1'b0;
        case (cap_funct3)
            3'b000: load_data = XLEN'($signed(lane_b));
            3'b001: begin
                load_data = XLEN'($signed(lane_h));
                mis_addr  = cap_alu[0];
            end
            3'b010: begin
                load_data = XLEN'($signed(lane_w));
                mis_addr  = |cap_alu[1:0];
            end
            3'b011: begin
                load_data = (XLEN == 64) ? i_mem_rdata : '0;
                mis_addr  = (XLEN == 64) && (|cap_alu[2:0]);
            end
            3'b100: load_data = XLEN'(lane_b);
            3'b101: begin
                load_data = XLEN'(lane_h);
                mis_addr  = cap_alu[0];
            end
            3'b110: begin
                load_data = (XLEN == 64) ? XLEN'(lane_w) : '0;
                mis_addr  = (XLEN == 64) && (|cap_alu[1:0]);
            end
            default: ;
        endcase
    end

    assign misalign = commit & (cap_res_src == SRC_MEM) & mis_addr;

    always_comb begin
        o_data = cap_alu;
        case (cap_res_src)
            SRC_MEM: o_data = load_data;
            SRC_PC:  o_data = {cap_pc_p4, 2'b00};
            SRC_CSR: o_data = cap_csr;
            default: o_data = cap_alu;
        endcase
    end

    assign o_rd         = cap_rd;
    assign o_misalign   = misalign;
    assign o_reg_write  = commit & cap_reg_write & (cap_rd != '0) & ~misalign;
    assign o_pend_valid = (state == ST_LOAD);
    assign o_pend_rd    = (state == ST_LOAD) ? cap_rd : '0;

endmodule

// File: tb/tb_rv_write_hs.sv
// tb/tb_rv_write_hs.sv - self-checking bench for rv_write_hs at XLEN 32 and 64
module tb_rv_write_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        regw;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [2:0]  f3;

    logic        v32, rvalid32, rdy32, owr32, mis32, pv32;
    logic [31:0] alu32, csr32, rdata32, d32;
    logic [29:0] pc32;
    logic [4:0]  ord32, prd32;

    logic        v64, rvalid64, rdy64, owr64, mis64, pv64;
    logic [63:0] alu64, csr64, rdata64, d64;
    logic [61:0] pc64;
    logic [4:0]  ord64, prd64;

    int n_cmp = 0;
    int n_fail = 0;

    rv_write_hs #(.XLEN(32), .RD_W(5)) dut32 (
        .i_clk(clk), .i_reset(rst), .i_valid(v32), .o_ready(rdy32),
        .i_alu_result(alu32), .i_csr_data(csr32), .i_pc_p4(pc32),
        .i_reg_write(regw), .i_rd(rd), .i_res_src(src), .i_funct3(f3),
        .i_mem_rvalid(rvalid32), .i_mem_rdata(rdata32),
        .o_data(d32), .o_rd(ord32), .o_reg_write(owr32), .o_misalign(mis32),
        .o_pend_valid(pv32), .o_pend_rd(prd32)
    );

    rv_write_hs #(.XLEN(64), .RD_W(5)) dut64 (
        .i_clk(clk), .i_reset(rst), .i_valid(v64), .o_ready(rdy64),
        .i_alu_result(alu64), .i_csr_data(csr64), .i_pc_p4(pc64),
        .i_reg_write(regw), .i_rd(rd), .i_res_src(src), .i_funct3(f3),
        .i_mem_rvalid(rvalid64), .i_mem_rdata(rdata64),
        .o_data(d64), .o_rd(ord64), .o_reg_write(owr64), .o_misalign(mis64),
        .o_pend_valid(pv64), .o_pend_rd(prd64)
    );

    // Reference load: pick the naturally aligned lane of the access size, then extend.
    function automatic logic [63:0] ref_load(input int xlen, input logic [2:0] fn,
                                             input logic [63:0] addr, input logic [63:0] word,
                                             output bit mis);
        int size;
        bit sgn;
        bit legal;
        int off;
        int lane;
        logic [63:0] v;
        logic [63:0] mask;
        size = 1; sgn = 1'b0; legal = 1'b1; mis = 1'b0;
        case (fn)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: begin size = 4; sgn = 1'b1; end
            3'd3: begin size = 8; legal = (xlen == 64); end
            3'd4: size = 1;
            3'd5: size = 2;
            3'd6: begin size = 4; legal = (xlen == 64); end
            default: legal = 1'b0;
        endcase
        if (!legal) return 64'd0;
        off  = int'(addr % 64'(xlen / 8));
        mis  = (off % size) != 0;
        lane = off / size;
        if (size == 8) return word;
        mask = (64'd1 << (size * 8)) - 64'd1;
        v = (word >> (lane * size * 8)) & mask;
        if (sgn && v[size*8-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic issue32(input logic [1:0] s, input logic [2:0] fn, input logic [31:0] a,
                           input logic [4:0] r, input logic [31:0] word);
        v32 = 1'b1; src = s; f3 = fn; alu32 = a; rd = r; regw = 1'b1;
        tick();
        v32 = 1'b0;
        if (s == 2'd1) begin rvalid32 = 1'b1; rdata32 = word; end
    endtask

    task automatic issue64(input logic [2:0] fn, input logic [63:0] a,
                           input logic [4:0] r, input logic [63:0] word);
        v64 = 1'b1; src = 2'd1; f3 = fn; alu64 = a; rd = r; regw = 1'b1;
        tick();
        v64 = 1'b0;
        rvalid64 = 1'b1; rdata64 = word;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
        n_cmp++;
        if ({rdy32, owr32, mis32, pv32, prd32, ord32, d32} !== {1'b1, 3'b000, 5'd0, 5'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset32: got rdy=%b wr=%b mis=%b pv=%b prd=%0d rd=%0d d=%h want 1 0 0 0 0 0 0",
                     rdy32, owr32, mis32, pv32, prd32, ord32, d32);
        end
        n_cmp++;
        if ({rdy64, owr64, mis64, pv64, prd64, ord64, d64} !== {1'b1, 3'b000, 5'd0, 5'd0, 64'd0}) begin
            n_fail++;
            $display("FAIL reset64: got rdy=%b wr=%b mis=%b pv=%b prd=%0d rd=%0d d=%h want 1 0 0 0 0 0 0",
                     rdy64, owr64, mis64, pv64, prd64, ord64, d64);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        v32 = 1'b1; src = 2'd0; rd = 5'd5; regw = 1'b1; alu32 = 32'h1234_5678;
        settle();
        n_cmp++;
        if (rdy32 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0: got %b want 1", rdy32); end
        tick();
        src = 2'd2; rd = 5'd1; pc32 = 30'h40;
        settle();
        n_cmp++;
        if ({rdy32, owr32, ord32, d32} !== {1'b1, 1'b1, 5'd5, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL b2b_alu: got rdy=%b wr=%b rd=%0d d=%h want 1 1 5 12345678", rdy32, owr32, ord32, d32);
        end
        tick();
        v32 = 1'b0;
        settle();
        n_cmp++;
        if ({rdy32, owr32, ord32, d32} !== {1'b1, 1'b1, 5'd1, 32'h0000_0100}) begin
            n_fail++;
            $display("FAIL b2b_pc: got rdy=%b wr=%b rd=%0d d=%h want 1 1 1 00000100", rdy32, owr32, ord32, d32);
        end
        tick();
        settle();
        n_cmp++;
        if (owr32 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got wr=%b want 0", owr32); end
        tick();
    endtask

    task automatic test_load_wait();
        v32 = 1'b1; src = 2'd1; f3 = 3'd0; alu32 = 32'hABCD_0003; rd = 5'd7; regw = 1'b1;
        tick();
        v32 = 1'b0;
        for (int w = 0; w < 3; w++) begin
            settle();
            n_cmp++;
            if ({rdy32, owr32, pv32, prd32} !== {1'b0, 1'b0, 1'b1, 5'd7}) begin
                n_fail++;
                $display("FAIL lb_wait%0d: got rdy=%b wr=%b pv=%b prd=%0d want 0 0 1 7", w, rdy32, owr32, pv32, prd32);
            end
            tick();
        end
        rvalid32 = 1'b1; rdata32 = 32'h80FF_0000;
        settle();
        n_cmp++;
        if ({rdy32, owr32, mis32, ord32, d32} !== {1'b1, 1'b1, 1'b0, 5'd7, 32'hFFFF_FF80}) begin
            n_fail++;
            $display("FAIL lb_commit: got rdy=%b wr=%b mis=%b rd=%0d d=%h want 1 1 0 7 ffffff80",
                     rdy32, owr32, mis32, ord32, d32);
        end
        tick();
        rvalid32 = 1'b0;
        settle();
        n_cmp++;
        if ({owr32, pv32} !== 2'b00) begin n_fail++; $display("FAIL lb_after: got wr=%b pv=%b want 0 0", owr32, pv32); end
        tick();
    endtask

    task automatic test_half();
        issue32(2'd1, 3'd5, 32'h0000_0002, 5'd4, 32'h8001_0000);
        settle();
        n_cmp++;
        if ({owr32, mis32, d32} !== {1'b1, 1'b0, 32'h0000_8001}) begin
            n_fail++;
            $display("FAIL lhu: got wr=%b mis=%b d=%h want 1 0 00008001", owr32, mis32, d32);
        end
        tick();
        rvalid32 = 1'b0;
        issue32(2'd1, 3'd1, 32'h0000_0001, 5'd4, 32'h8001_0000);
        settle();
        n_cmp++;
        if ({owr32, mis32} !== 2'b01) begin
            n_fail++;
            $display("FAIL lh_misalign: got wr=%b mis=%b want 0 1", owr32, mis32);
        end
        tick();
        rvalid32 = 1'b0;
        settle();
        n_cmp++;
        if (mis32 !== 1'b0) begin n_fail++; $display("FAIL misalign_pulse: got %b want 0", mis32); end
        tick();
    endtask

    task automatic test_x0_csr();
        issue32(2'd0, 3'd0, 32'h0000_0055, 5'd0, 32'd0);
        settle();
        n_cmp++;
        if (owr32 !== 1'b0) begin n_fail++; $display("FAIL x0_write: got wr=%b want 0", owr32); end
        tick();
        csr32 = 32'hDEAD_BEEF;
        issue32(2'd3, 3'd0, 32'd0, 5'd3, 32'd0);
        settle();
        n_cmp++;
        if ({owr32, ord32, d32} !== {1'b1, 5'd3, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL csr: got wr=%b rd=%0d d=%h want 1 3 deadbeef", owr32, ord32, d32);
        end
        tick();
        rvalid32 = 1'b1; rdata32 = $urandom;
        settle();
        n_cmp++;
        if ({rdy32, owr32, pv32, mis32} !== 4'b1000) begin
            n_fail++;
            $display("FAIL stray_rvalid: got rdy=%b wr=%b pv=%b mis=%b want 1 0 0 0", rdy32, owr32, pv32, mis32);
        end
        tick();
        rvalid32 = 1'b0;
    endtask

    task automatic test_reset_in_load();
        v32 = 1'b1; src = 2'd1; f3 = 3'd0; alu32 = 32'h0000_0003; rd = 5'd7; regw = 1'b1;
        tick();
        v32 = 1'b0;
        settle();
        n_cmp++;
        if (pv32 !== 1'b1) begin n_fail++; $display("FAIL rst_load_pend: got pv=%b want 1", pv32); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rvalid32 = 1'b1; rdata32 = 32'hFFFF_FFFF;
        settle();
        n_cmp++;
        if ({rdy32, owr32, mis32, pv32, prd32, ord32, d32} !== {1'b1, 3'b000, 5'd0, 5'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL rst_load: got rdy=%b wr=%b mis=%b pv=%b prd=%0d rd=%0d d=%h want 1 0 0 0 0 0 0",
                     rdy32, owr32, mis32, pv32, prd32, ord32, d32);
        end
        tick();
        rvalid32 = 1'b0;
    endtask

    task automatic test_random32();
        logic [1:0]  s;
        logic [2:0]  fn;
        logic [31:0] a, word, c, exp;
        logic [29:0] p;
        logic [4:0]  r;
        logic        rw, exp_wr;
        bit          exp_mis;
        int          wt;
        for (int i = 0; i < 150; i++) begin
            s = 2'($urandom); fn = 3'($urandom); a = $urandom; word = $urandom; c = $urandom;
            p = 30'($urandom); r = 5'($urandom); rw = 1'($urandom); wt = $urandom_range(0, 3);
            v32 = 1'b1; src = s; f3 = fn; alu32 = a; csr32 = c; pc32 = p; rd = r; regw = rw;
            settle();
            n_cmp++;
            if (rdy32 !== 1'b1) begin n_fail++; $display("FAIL rnd32_ready[%0d]: got %b want 1", i, rdy32); end
            tick();
            v32 = 1'b0;
            exp_mis = 1'b0;
            case (s)
                2'd0: exp = a;
                2'd1: exp = 32'(ref_load(32, fn, 64'(a), 64'(word), exp_mis));
                2'd2: exp = {p, 2'b00};
                default: exp = c;
            endcase
            if (s == 2'd1) begin
                for (int w = 0; w < wt; w++) begin
                    settle();
                    n_cmp++;
                    if ({rdy32, owr32, pv32, prd32} !== {1'b0, 1'b0, 1'b1, r}) begin
                        n_fail++;
                        $display("FAIL rnd32_wait[%0d]: got rdy=%b wr=%b pv=%b prd=%0d want 0 0 1 %0d",
                                 i, rdy32, owr32, pv32, prd32, r);
                    end
                    tick();
                end
                rvalid32 = 1'b1; rdata32 = word;
            end
            exp_wr = rw && (r != 5'd0) && !exp_mis;
            settle();
            n_cmp++;
            if ({owr32, mis32} !== {exp_wr, exp_mis}) begin
                n_fail++;
                $display("FAIL rnd32_flags[%0d]: got wr=%b mis=%b want %b %b (src=%0d f3=%0d a=%h)",
                         i, owr32, mis32, exp_wr, exp_mis, s, fn, a);
            end
            if (exp_wr) begin
                n_cmp++;
                if ({ord32, d32} !== {r, exp}) begin
                    n_fail++;
                    $display("FAIL rnd32_data[%0d]: got rd=%0d d=%h want %0d %h (src=%0d f3=%0d a=%h w=%h)",
                             i, ord32, d32, r, exp, s, fn, a, word);
                end
            end
            tick();
            rvalid32 = 1'b0;
        end
    endtask

    task automatic test_xlen64();
        logic [2:0]  fn;
        logic [63:0] a, word, exp;
        logic [4:0]  r;
        bit          exp_mis;
        issue64(3'd6, 64'h4, 5'd9, 64'hF000_0001_0000_0000);
        settle();
        n_cmp++;
        if ({owr64, mis64, d64} !== {1'b1, 1'b0, 64'h0000_0000_F000_0001}) begin
            n_fail++;
            $display("FAIL lwu64: got wr=%b mis=%b d=%h want 1 0 00000000f0000001", owr64, mis64, d64);
        end
        tick();
        rvalid64 = 1'b0;
        issue64(3'd3, 64'h8, 5'd10, 64'h8765_4321_0FED_CBA9);
        settle();
        n_cmp++;
        if ({owr64, mis64, d64} !== {1'b1, 1'b0, 64'h8765_4321_0FED_CBA9}) begin
            n_fail++;
            $display("FAIL ld64: got wr=%b mis=%b d=%h want 1 0 876543210fedcba9", owr64, mis64, d64);
        end
        tick();
        rvalid64 = 1'b0;
        issue64(3'd3, 64'h4, 5'd10, 64'h1);
        settle();
        n_cmp++;
        if ({owr64, mis64} !== 2'b01) begin
            n_fail++;
            $display("FAIL ld64_misalign: got wr=%b mis=%b want 0 1", owr64, mis64);
        end
        tick();
        rvalid64 = 1'b0;
        for (int i = 0; i < 80; i++) begin
            fn = 3'($urandom); a = {$urandom, $urandom}; word = {$urandom, $urandom}; r = 5'($urandom);
            exp = ref_load(64, fn, a, word, exp_mis);
            issue64(fn, a, r, word);
            settle();
            n_cmp++;
            if ({owr64, mis64} !== {(r != 5'd0) && !exp_mis, exp_mis}) begin
                n_fail++;
                $display("FAIL rnd64_flags[%0d]: got wr=%b mis=%b want mis=%b (f3=%0d a=%h rd=%0d)",
                         i, owr64, mis64, exp_mis, fn, a, r);
            end
            if ((r != 5'd0) && !exp_mis) begin
                n_cmp++;
                if (d64 !== exp) begin
                    n_fail++;
                    $display("FAIL rnd64_data[%0d]: got %h want %h (f3=%0d a=%h w=%h)", i, d64, exp, fn, a, word);
                end
            end
            tick();
            rvalid64 = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; regw = 1'b0; rd = '0; src = '0; f3 = '0;
        v32 = 1'b0; rvalid32 = 1'b0; alu32 = '0; csr32 = '0; rdata32 = '0; pc32 = '0;
        v64 = 1'b0; rvalid64 = 1'b0; alu64 = '0; csr64 = '0; rdata64 = '0; pc64 = '0;
        #1;
        test_reset();
        test_back_to_back();
        test_load_wait();
        test_half();
        test_x0_csr();
        test_reset_in_load();
        test_random32();
        test_xlen64();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_write_hs.md
# rv_write_hs

Parametrised writeback stage with a memory-response handshake. Captures one retiring instruction from the memory stage and, for loads, waits any number of cycles for the data-memory read response. It then extracts and sign- or zero-extends the addressed byte, half, word or (XLEN=64) double, selects the result source and drives the register-file write port. It sits between the memory stage and the register file and exports the pending-load destination to the hazard unit.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values 32 and 64.
- RD_W, 5: register index width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  memory stage presents an instruction.
- o_ready  out  1  stage accepts the instruction this cycle.
- i_alu_result  in  XLEN  ALU result; also the load address (low bits select lanes).
- i_csr_data  in  XLEN  CSR read value.
- i_pc_p4  in  XLEN-2  PC+4, bits [XLEN-1:2].
- i_reg_write  in  1  instruction writes rd.
- i_rd  in  RD_W  destination register.
- i_res_src  in  2  result source: 0 ALU, 1 MEMORY, 2 PC_P4, 3 CSR.
- i_funct3  in  3  load size/sign code.
- i_mem_rvalid  in  1  read-response valid.
- i_mem_rdata  in  XLEN  read-response data, naturally aligned bus word.
- o_data  out  XLEN  register-file write data.
- o_rd  out  RD_W  register-file write index.
- o_reg_write  out  1  register-file write enable, one pulse per commit.
- o_misalign  out  1  one-cycle pulse: committed load was misaligned.
- o_pend_valid  out  1  a load is waiting for its response.
- o_pend_rd  out  RD_W  rd of the pending load.

## Operation
- Accept = i_valid & o_ready. On accept, register alu_result, csr_data, pc_p4, reg_write, rd, res_src and funct3.
- States:
  - EMPTY: o_ready=1, no commit. Accept of a MEMORY op -> LOAD; accept of any other op -> DONE; no accept -> stay.
  - DONE: commits the captured op this cycle. o_ready=1. Next state follows the same accept rule as EMPTY, else EMPTY.
  - LOAD: o_ready = i_mem_rvalid. Without rvalid: hold, no commit. With rvalid: commit using i_mem_rdata in the same cycle, then follow the accept rule, else EMPTY.
- i_mem_rvalid outside LOAD is ignored.
- Result select:
  - ALU -> alu_result.
  - PC_P4 -> {pc_p4, 2'b00}.
  - CSR -> csr_data.
  - MEMORY -> extracted load data.
- Lane offset:
  - XLEN=32: addr[1:0].
  - XLEN=64: addr[2:0].
  - Byte lane = offset. Half lane = offset>>1. Word lane = offset>>2 (64 only).
- funct3 decode:
  - 000 LB, 001 LH, 010 LW: sign-extend.
  - 100 LBU, 101 LHU: zero-extend.
  - 011 LD: XLEN=64 only.
  - 110 LWU: XLEN=64 only, zero-extend.
  - Any other code, or LD/LWU with XLEN=32: data 0.
  - LW with XLEN=32 passes the whole word.
- Misalignment:
  - Half with addr[0]=1.
  - Word with addr[1:0]!=0.
  - Double with addr[2:0]!=0.
  - On a misaligned load commit: o_misalign=1, o_reg_write=0, o_data still driven.
- o_reg_write = commit & reg_write & (rd!=0) & !misalign. Never write x0.
- o_pend_valid = (state==LOAD); o_pend_rd = captured rd (0 when not LOAD).
- o_data/o_rd outside a commit cycle: hold last captured values. Don't-care to consumers; the bench checks them only when o_reg_write=1.

## Timing
- Reset (synchronous, dominates accept and rvalid):
  - state EMPTY; all captured fields 0.
  - o_reg_write=0, o_misalign=0, o_pend_valid=0, o_pend_rd=0, o_data=0, o_rd=0.
  - o_ready=1 from the first cycle after reset.
  - Reset during LOAD abandons the load; a late rvalid is ignored.
- Non-load latency: accept at edge N -> commit in cycle N+1 (combinational from registers).
- Load latency: commit in the first cycle ≥N+1 with i_mem_rvalid=1. Zero-wait memory gives throughput 1/cycle.
- Back-to-back: the commit cycle and the next accept cycle coincide; no bubble.
- o_ready is combinational from state and i_mem_rvalid. It never depends on i_valid.
- Upstream must hold its fields stable while i_valid & !o_ready.

## Test plan
- ALU op rd=5, alu_result=0x1234_5678, then PC_P4 op rd=1, pc_p4=0x100>>2 on consecutive cycles -> writes x5=0x12345678 then x1=0x00000100 on successive cycles; o_ready stays 1.
- LB, addr=0x...3, rdata=0x80FF_0000, rvalid 3 cycles late -> o_ready=0 and o_pend_valid=1, o_pend_rd=rd for 3 cycles; then o_data=0xFFFF_FF80, one write pulse.
- LHU addr=0x2, rdata=0x8001_0000 -> 0x0000_8001. LH addr=0x1 -> o_misalign=1, o_reg_write=0.
- XLEN=64:
  - LWU addr=0x4, rdata=0xF000_0001_0000_0000 -> 0x0000_0000_F000_0001.
  - LD addr=0x8 -> full 64-bit rdata.
  - LD addr=0x4 -> misalign.
- ALU op with rd=0 and CSR op rd=3, csr=0xDEAD_BEEF -> no write for x0, x3=0xDEADBEEF. Stray rvalid in EMPTY -> no effect.
- Assert i_reset while in LOAD, then rvalid the next cycle -> no write, state EMPTY, all outputs at reset values.
